sprite_draw_scheduler: RTL and testbench

Round-robin scheduler that shares one `drawSprite` engine among `NUM_REQ` sprite requesters (player, enemies, projectiles, HUD). It latches one requester's draw parameters and drives the engine's Enable/Done handshake to completion. It then acknowledges the requester and moves on. It sits between the game-object logic and `drawSprite`; the engine's VGA outputs bypass it.

---
 rtl/sprite_sched_pkg.sv | 36 +++
 rtl/sprite_draw_scheduler_rr_arbiter.sv | 55 +++++
 rtl/sprite_draw_scheduler.sv | 147 ++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite draw scheduler and the drawSprite engine.
package sprite_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ACK     = 2'd3
    } sched_state_t;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int SPRITE_W = 3;
    localparam int ANIM_W   = 3;
    localparam int SIZE_W   = 5;
    localparam int ID_W     = 3;
    localparam int WDOG_W   = 17;
    localparam int MAX_REQ  = 8;

    // Pixel value the engine treats as "do not draw".
    localparam logic [8:0] TRANSPARENT_COLOUR = 9'b100101110;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [SPRITE_W-1:0] sprite;
        logic [ANIM_W-1:0]   anim;
        logic [SIZE_W-1:0]   width;
        logic [SIZE_W-1:0]   height;
    } sprite_fields_t;

    function automatic logic is_zero_size(input sprite_fields_t f);
        return (f.width == '0) || (f.height == '0);
    endfunction

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first high request at or after Ptr, wrapping.
module rr_arbiter
    import sprite_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] Req,
    input  logic [ID_W-1:0]    Ptr,
    output logic [NUM_REQ-1:0] Grant,
    output logic [ID_W-1:0]    GrantIdx,
    output logic               Any
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(NUM_REQ);

    logic [MAX_REQ-1:0] w_req_pad;
    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_offset;
    logic [ID_W:0]      w_sum;

    assign w_req_pad = MAX_REQ'(Req);

    // w_rot[k] is the request k positions after Ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [ID_W:0]   w_pos;
            logic [ID_W-1:0] w_wrapped;
            assign w_pos     = {1'b0, Ptr} + (ID_W+1)'(gi);
            assign w_wrapped = (w_pos >= N_W) ? ID_W'(w_pos - N_W) : ID_W'(w_pos);
            assign w_rot[gi] = w_req_pad[w_wrapped];
        end
    endgenerate

    always_comb begin
        w_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = ID_W'(k);
            end
        end
    end

    assign Any      = |Req;
    assign w_sum    = {1'b0, Ptr} + {1'b0, w_offset};
    assign GrantIdx = (w_sum >= N_W) ? ID_W'(w_sum - N_W) : ID_W'(w_sum);

    always_comb begin
        Grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            Grant[k] = Any && (GrantIdx == ID_W'(k));
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares one drawSprite engine among NUM_REQ requesters: round-robin grant,
// parameter latch, Enable/Done handshake with watchdog, one-cycle Ack.
module sprite_draw_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [X_W*NUM_REQ-1:0]       ReqX,
    input  logic [Y_W*NUM_REQ-1:0]       ReqY,
    input  logic [SPRITE_W*NUM_REQ-1:0]  ReqSprite,
    input  logic [ANIM_W*NUM_REQ-1:0]    ReqAnim,
    input  logic [SIZE_W*NUM_REQ-1:0]    ReqWidth,
    input  logic [SIZE_W*NUM_REQ-1:0]    ReqHeight,
    input  logic                         EngDone,
    output logic                         EngEnable,
    output logic [X_W-1:0]               EngX,
    output logic [Y_W-1:0]               EngY,
    output logic [SPRITE_W-1:0]          EngSprite,
    output logic [ANIM_W-1:0]            EngAnim,
    output logic [SIZE_W-1:0]            EngWidth,
    output logic [SIZE_W-1:0]            EngHeight,
    output logic [NUM_REQ-1:0]           Ack,
    output logic [ID_W-1:0]              GrantId,
    output logic                         Busy,
    output logic                         Timeout
);

    sched_state_t       r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_grant_id;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    sprite_fields_t     r_fields;
    logic [WDOG_W-1:0]  r_wdog;
    logic               r_eng_enable;
    logic               r_busy;
    logic               r_timeout;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any;
    sprite_fields_t     w_fields [MAX_REQ];
    sprite_fields_t     w_sel;
    logic [WDOG_W-1:0]  w_wdog_next;
    logic [ID_W-1:0]    w_ptr_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .Req      (Req),
        .Ptr      (r_ptr),
        .Grant    (w_grant),
        .GrantIdx (w_grant_idx),
        .Any      (w_any)
    );

    // Unpack per-requester fields into a fixed 8-entry table so the 3-bit index is always in range.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_fields
            if (gi < NUM_REQ) begin : g_live
                assign w_fields[gi] = '{
                    x:      ReqX[gi*X_W +: X_W],
                    y:      ReqY[gi*Y_W +: Y_W],
                    sprite: ReqSprite[gi*SPRITE_W +: SPRITE_W],
                    anim:   ReqAnim[gi*ANIM_W +: ANIM_W],
                    width:  ReqWidth[gi*SIZE_W +: SIZE_W],
                    height: ReqHeight[gi*SIZE_W +: SIZE_W]
                };
            end else begin : g_pad
                assign w_fields[gi] = '0;
            end
        end
    endgenerate

    assign w_sel       = w_fields[w_grant_idx];
    assign w_wdog_next = r_wdog + WDOG_W'(1);
    assign w_ptr_next  = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_grant_id   <= '0;
            r_grant      <= '0;
            r_ack        <= '0;
            r_fields     <= '0;
            r_wdog       <= '0;
            r_eng_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_ack        <= '0;
            // Enable trails the state by one cycle: rises after grant, falls after Done.
            r_eng_enable <= (r_state == ST_ISSUE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_fields   <= w_sel;
                        r_grant_id <= w_grant_idx;
                        r_grant    <= w_grant;
                        r_wdog     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= is_zero_size(w_sel) ? ST_ACK : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wdog <= w_wdog_next;
                    if (EngDone) begin
                        r_state <= ST_RELEASE;
                    end else if (w_wdog_next == WDOG_W'(TIMEOUT)) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!EngDone) begin
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack   <= r_grant;
                    r_ptr   <= w_ptr_next;
                    r_wdog  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign EngEnable = r_eng_enable;
    assign EngX      = r_fields.x;
    assign EngY      = r_fields.y;
    assign EngSprite = r_fields.sprite;
    assign EngAnim   = r_fields.anim;
    assign EngWidth  = r_fields.width;
    assign EngHeight = r_fields.height;
    assign Ack       = r_ack;
    assign GrantId   = r_grant_id;
    assign Busy      = r_busy;
    assign Timeout   = r_timeout;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench: scoreboard of expected grants plus hand sequences for timing corners.
module tb_sprite_draw_scheduler;

    localparam int N  = 4;
    localparam int TO = 100;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_x = '0;
    logic [7*N-1:0] req_y = '0;
    logic [3*N-1:0] req_s = '0;
    logic [3*N-1:0] req_a = '0;
    logic [5*N-1:0] req_w = '0;
    logic [5*N-1:0] req_h = '0;
    logic           eng_done = 1'b0;

    logic           eng_en;
    logic [7:0]     eng_x;
    logic [6:0]     eng_y;
    logic [2:0]     eng_s;
    logic [2:0]     eng_a;
    logic [4:0]     eng_w;
    logic [4:0]     eng_h;
    logic [N-1:0]   ack;
    logic [2:0]     grant_id;
    logic           busy;
    logic           tmo;

    sprite_draw_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .Clock     (clk),
        .Resetn    (rst_n),
        .Req       (req),
        .ReqX      (req_x),
        .ReqY      (req_y),
        .ReqSprite (req_s),
        .ReqAnim   (req_a),
        .ReqWidth  (req_w),
        .ReqHeight (req_h),
        .EngDone   (eng_done),
        .EngEnable (eng_en),
        .EngX      (eng_x),
        .EngY      (eng_y),
        .EngSprite (eng_s),
        .EngAnim   (eng_a),
        .EngWidth  (eng_w),
        .EngHeight (eng_h),
        .Ack       (ack),
        .GrantId   (grant_id),
        .Busy      (busy),
        .Timeout   (tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] s;
        logic [2:0] a;
        logic [4:0] w;
        logic [4:0] h;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [7:0]  xb;
        logic [6:0]  yb;
        logic [4:0]  w;
        logic [4:0]  h;
        int          n;
        logic [11:0] ord;   // grant order, first grant in bits [2:0]
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   checks = 0;
    int   failures = 0;
    int   en_cycles = 0;
    int   eng_cnt = 0;
    int   draw_len = 5;
    bit   eng_hang = 1'b0;
    int   en0;

    // drawSprite model: Done after draw_len enabled cycles, held until Enable drops.
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                eng_done = 1'b0;
                eng_cnt  = 0;
            end else if (eng_en) begin
                en_cycles++;
                if (!eng_hang && eng_cnt >= draw_len - 1) eng_done = 1'b1;
                else eng_cnt++;
            end else begin
                eng_done = 1'b0;
                eng_cnt  = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y,
                           input logic [4:0] w, input logic [4:0] h);
        req_x[i*8 +: 8] = x;
        req_y[i*7 +: 7] = y;
        req_s[i*3 +: 3] = 3'(i);
        req_a[i*3 +: 3] = 3'(7 - i);
        req_w[i*5 +: 5] = w;
        req_h[i*5 +: 5] = h;
    endtask

    task automatic push(input int i);
        exp_t e;
        e.id = 3'(i);
        e.x  = req_x[i*8 +: 8];
        e.y  = req_y[i*7 +: 7];
        e.s  = req_s[i*3 +: 3];
        e.a  = req_a[i*3 +: 3];
        e.w  = req_w[i*5 +: 5];
        e.h  = req_h[i*5 +: 5];
        sb.push_back(e);
    endtask

    // Watch for Ack pulses, compare against the scoreboard, drop the acked Req bit.
    task automatic run_acks(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        exp_t e;
        logic [N-1:0] onehot;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    e = sb.pop_front();
                    onehot = N'(1) << e.id;
                    $display("ack vec=%b id=%0d x=%0d y=%0d w=%0d h=%0d (expect id=%0d x=%0d)",
                             ack, grant_id, eng_x, eng_y, eng_w, eng_h, e.id, e.x);
                    chk("ack_vec", 64'(ack), 64'(onehot));
                    chk("grant_id", 64'(grant_id), 64'(e.id));
                    chk("eng_fields", 64'({eng_x, eng_y, eng_s, eng_a, eng_w, eng_h}),
                        64'({e.x, e.y, e.s, e.a, e.w, e.h}));
                end
                req = req & ~ack;
                got++;
            end
        end
        chk("ack_wait", 64'(got), 64'(n));
    endtask

    task automatic wait_en(input int budget);
        int c = 0;
        while (!eng_en && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("enable_wait", 64'(eng_en), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        tbl[0] = '{mask: 4'b1111, xb: 8'd40, yb: 7'd1,  w: 5'd4, h: 5'd3, n: 4, ord: {3'd1, 3'd0, 3'd3, 3'd2}};
        tbl[1] = '{mask: 4'b0101, xb: 8'd80, yb: 7'd9,  w: 5'd2, h: 5'd2, n: 2, ord: {3'd0, 3'd0, 3'd0, 3'd2}};
        tbl[2] = '{mask: 4'b1010, xb: 8'd120, yb: 7'd33, w: 5'd7, h: 5'd1, n: 2, ord: {3'd0, 3'd0, 3'd3, 3'd1}};
        tbl[3] = '{mask: 4'b1111, xb: 8'd200, yb: 7'd90, w: 5'd31, h: 5'd31, n: 4, ord: {3'd3, 3'd2, 3'd1, 3'd0}};
        tbl[4] = '{mask: 4'b0100, xb: 8'd5,  yb: 7'd5,  w: 5'd5, h: 5'd0, n: 1, ord: {3'd0, 3'd0, 3'd0, 3'd2}};
        tbl[5] = '{mask: 4'b0011, xb: 8'd250, yb: 7'd120, w: 5'd1, h: 5'd9, n: 2, ord: {3'd0, 3'd0, 3'd1, 3'd0}};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_enable", 64'(eng_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_timeout", 64'(tmo), 64'd0);
        chk("rst_fields", 64'({eng_x, eng_y, eng_s, eng_a, eng_w, eng_h}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request with 1-cycle grant latency
        draw_len = 64;
        set_req(1, 8'd10, 7'd20, 5'd8, 5'd8);
        push(1);
        req = 4'b0010;
        @(posedge clk); #1;
        chk("grant_busy", 64'(busy), 64'd1);
        chk("grant_en_latency", 64'(eng_en), 64'd0);
        @(posedge clk); #1;
        chk("en_high", 64'(eng_en), 64'd1);
        chk("single_eng_x", 64'(eng_x), 64'd10);
        run_acks(1, 200);

        // Table: contention and round-robin order from the current pointer
        draw_len = 5;
        for (int r = 0; r < 6; r++) begin
            logic [11:0] o;
            o = tbl[r].ord;
            for (int i = 0; i < N; i++) begin
                if (tbl[r].mask[i]) set_req(i, tbl[r].xb + 8'(i), tbl[r].yb + 7'(i), tbl[r].w, tbl[r].h);
            end
            for (int k = 0; k < tbl[r].n; k++) push(int'(o[3*k +: 3]));
            req = tbl[r].mask;
            run_acks(tbl[r].n, 40 * tbl[r].n);
        end

        // Zero-size: Ack two cycles after the request, engine never enabled
        @(negedge clk);
        set_req(0, 8'd33, 7'd44, 5'd0, 5'd7);
        @(posedge clk); #1;
        en0 = en_cycles;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("zero_ack_early", 64'(ack), 64'd0);
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_en_a", 64'(eng_en), 64'd0);
        @(negedge clk);
        chk("zero_ack", 64'(ack), 64'b0001);
        chk("zero_eng_x", 64'(eng_x), 64'd33);
        chk("zero_en_b", 64'(eng_en), 64'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("zero_ack_once", 64'(ack), 64'd0);
        @(posedge clk); #1;
        chk("zero_no_enable", 64'(en_cycles - en0), 64'd0);

        // Field stability: change ReqX mid-draw, latched value holds until next grant
        @(negedge clk);
        draw_len = 20;
        set_req(1, 8'd50, 7'd21, 5'd6, 5'd6);
        push(1);
        req = 4'b0010;
        wait_en(20);
        set_req(1, 8'd99, 7'd21, 5'd6, 5'd6);
        @(negedge clk);
        chk("stable_x", 64'(eng_x), 64'd50);
        run_acks(1, 100);
        push(1);
        req = 4'b0010;
        run_acks(1, 100);

        // Watchdog: engine never signals Done
        eng_hang = 1'b1;
        set_req(3, 8'd7, 7'd8, 5'd4, 5'd4);
        push(3);
        @(posedge clk); #1;
        en0 = en_cycles;
        req = 4'b1000;
        wait_en(20);
        repeat (50) @(negedge clk);
        chk("tmo_not_yet", 64'(tmo), 64'd0);
        run_acks(1, 300);
        @(posedge clk); #1;
        chk("tmo_set", 64'(tmo), 64'd1);
        chk("tmo_enable_cycles", 64'(en_cycles - en0), 64'd100);
        eng_hang = 1'b0;
        draw_len = 5;
        @(negedge clk);
        set_req(0, 8'd1, 7'd2, 5'd3, 5'd3);
        push(0);
        req = 4'b0001;
        run_acks(1, 100);
        chk("tmo_sticky", 64'(tmo), 64'd1);

        // Reset during ISSUE: immediate reset values, no Ack, pointer back to 0
        set_req(2, 8'd60, 7'd30, 5'd5, 5'd5);
        draw_len = 30;
        req = 4'b0100;
        wait_en(20);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", 64'(eng_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
        chk("mid_rst_eng_x", 64'(eng_x), 64'd0);
        chk("mid_rst_timeout", 64'(tmo), 64'd0);
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_no_ack", 64'(ack), 64'd0);
        end
        rst_n = 1'b1;
        draw_len = 5;
        set_req(0, 8'd70, 7'd10, 5'd2, 5'd2);
        set_req(3, 8'd73, 7'd13, 5'd2, 5'd2);
        push(0);
        push(3);
        req = 4'b1001;
        run_acks(2, 100);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
